// File: rtl/cordic_job_sequencer_pkg.sv
// Shared types and default constants for the CORDIC job sequencer.
// Holds the FSM state encoding and the default RAM mailbox addresses.
package cordic_seq_pkg;

   localparam int unsigned CYC_W = 16;

   localparam logic [7:0] DEF_OP_ADDR  = 8'hF0;
   localparam logic [7:0] DEF_COS_ADDR = 8'hF1;
   localparam logic [7:0] DEF_SIN_ADDR = 8'hF2;

   typedef enum logic [2:0] {
      IDLE,
      WRITE_OP,
      START,
      RUN,
      RD_COS,
      RD_SIN,
      CAP_SIN,
      PRESENT
   } seq_state_t;

endpackage

// File: rtl/cordic_job_sequencer_if.sv
// Host-side job/result handshake bundle for the CORDIC job sequencer.
// master = host, slave = sequencer.
interface cordic_job_sequencer_if #(
   parameter int unsigned DATA_W = 32
);
   import cordic_seq_pkg::*;

   logic              job_valid;
   logic              job_ready;
   logic [DATA_W-1:0] job_data;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_cos;
   logic [DATA_W-1:0] res_sin;
   logic              res_err;
   logic [CYC_W-1:0]  res_cycles;

   modport master (
      output job_valid, job_data, res_ready,
      input  job_ready, res_valid, res_cos, res_sin,
      input  res_err, res_cycles
   );

   modport slave (
      input  job_valid, job_data, res_ready,
      output job_ready, res_valid, res_cos, res_sin,
      output res_err, res_cycles
   );

endinterface

// File: rtl/cordic_job_sequencer.sv
// Host-side job sequencer for the CORDIC processor and its shared RAM.
// Owns the single RAM port and lends it to the processor only in RUN.
module cordic_job_sequencer
   import cordic_seq_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter logic [ADDR_W-1:0] OP_ADDR  = ADDR_W'(DEF_OP_ADDR),
   parameter logic [ADDR_W-1:0] COS_ADDR = ADDR_W'(DEF_COS_ADDR),
   parameter logic [ADDR_W-1:0] SIN_ADDR = ADDR_W'(DEF_SIN_ADDR),
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   cordic_job_sequencer_if.slave host,
   output logic              busy,
   output logic              cpu_run,
   input  logic              cpu_done,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CYC_W-1:0] CYC_MAX = '1;

   seq_state_t        state_q, state_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic [CYC_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] cos_q, cos_d;
   logic [DATA_W-1:0] sin_q, sin_d;
   logic              err_q, err_d;
   logic [31:0]       run_n;

   assign run_n = 32'(cnt_q) + 32'd1;

   assign busy            = (state_q != IDLE);
   assign host.job_ready  = (state_q == IDLE);
   assign host.res_valid  = (state_q == PRESENT);
   assign host.res_cos    = cos_q;
   assign host.res_sin    = sin_q;
   assign host.res_err    = err_q;
   assign host.res_cycles = cnt_q;

   // Next-state, datapath updates and RAM port mux.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      cos_d     = cos_q;
      sin_d     = sin_q;
      err_d     = err_q;
      cpu_run   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         IDLE: begin
            if (host.job_valid) begin
               op_d    = host.job_data;
               state_d = WRITE_OP;
            end
         end
         WRITE_OP: begin
            mem_we    = 1'b1;
            mem_addr  = OP_ADDR;
            mem_wdata = op_q;
            state_d   = START;
         end
         START: begin
            cpu_run = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cnt_d     = (cnt_q == CYC_MAX) ? cnt_q : cnt_q + 1'b1;
            // A Done seen in the first RUN cycle is left over from the last job.
            if ((cnt_q != '0) && cpu_done) begin
               state_d = RD_COS;
            end else if (run_n >= 32'(TIMEOUT)) begin
               err_d   = 1'b1;
               cos_d   = '0;
               sin_d   = '0;
               state_d = PRESENT;
            end
         end
         RD_COS: begin
            mem_addr = COS_ADDR;
            state_d  = RD_SIN;
         end
         RD_SIN: begin
            mem_addr = SIN_ADDR;
            cos_d    = mem_rdata;
            state_d  = CAP_SIN;
         end
         CAP_SIN: begin
            sin_d   = mem_rdata;
            err_d   = 1'b0;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (host.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         cos_q   <= '0;
         sin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Self-checking bench for cordic_job_sequencer.
// Processor and RAM are behavioural models; results go through a scoreboard.
module tb_cordic_job_sequencer;

   localparam logic [7:0] OP_A  = 8'hF0;
   localparam logic [7:0] COS_A = 8'hF1;
   localparam logic [7:0] SIN_A = 8'hF2;
   localparam int TMO = 64;

   typedef struct {
      logic [31:0] op;
      logic [31:0] cosv;
      logic [31:0] sinv;
      int          done_at;
      bit          wr;
      bit          stale;
      int          hold;
      logic [31:0] e_cos;
      logic [31:0] e_sin;
      bit          e_err;
      int          e_cyc;
      int          e_lat;
   } vec_t;

   typedef struct {
      logic [31:0] op;
      logic [31:0] cosv;
      logic [31:0] sinv;
      bit          err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy, cpu_run, cpu_done, cpu_we, mem_we;
   logic [7:0]  cpu_addr, mem_addr;
   logic [31:0] cpu_wdata, mem_wdata, mem_rdata;
   logic [31:0] ram [256];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int run_pulses = 0;
   int rd_hits = 0;
   int rd0 = 0;
   int pulse0 = 0;

   int          run_k = 0;
   int          m_done_at = 0;
   bit          m_wr = 1'b0;
   bit          m_stale = 1'b0;
   bit          f_en = 1'b0;
   logic [31:0] m_cos = '0;
   logic [31:0] m_sin = '0;

   exp_t sb[$];
   vec_t tbl[5];

   cordic_job_sequencer_if #(.DATA_W(32)) hif ();

   cordic_job_sequencer #(
      .ADDR_W(8), .DATA_W(32), .OP_ADDR(OP_A), .COS_ADDR(COS_A),
      .SIN_ADDR(SIN_A), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .host(hif), .busy(busy),
      .cpu_run(cpu_run), .cpu_done(cpu_done), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM with registered read, plus cycle/event counters.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
      cyc <= cyc + 1;
      if (cpu_run) run_pulses <= run_pulses + 1;
      if (!mem_we && (mem_addr == COS_A || mem_addr == SIN_A))
         rd_hits <= rd_hits + 1;
   end

   // Processor model: tracks which RUN cycle the sequencer is in.
   always @(posedge clk) begin
      if (rst || !busy) run_k <= 0;
      else if (cpu_run) run_k <= 1;
      else if (run_k != 0) begin
         if (cpu_done && run_k > 1) run_k <= 0;
         else run_k <= run_k + 1;
      end
   end

   always_comb begin
      cpu_we = 1'b0;
      cpu_addr = 8'h00;
      cpu_wdata = 32'h0;
      if (f_en) begin
         cpu_we = 1'b1;
         cpu_addr = 8'h10;
         cpu_wdata = 32'h5A5A_5A5A;
      end else if (m_wr && run_k == 1) begin
         cpu_we = 1'b1;
         cpu_addr = COS_A;
         cpu_wdata = m_cos;
      end else if (m_wr && run_k == 2) begin
         cpu_we = 1'b1;
         cpu_addr = SIN_A;
         cpu_wdata = m_sin;
      end
      cpu_done = (run_k != 0 && run_k == m_done_at) ||
                 (m_stale && run_k == 1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input vec_t v);
      exp_t e;
      e.op = v.op;
      e.cosv = v.e_cos;
      e.sinv = v.e_sin;
      e.err = v.e_err;
      e.cyc = v.e_cyc;
      return e;
   endfunction

   task automatic setup_model(input vec_t v);
      m_cos = v.cosv;
      m_sin = v.sinv;
      m_done_at = v.done_at;
      m_wr = v.wr;
      m_stale = v.stale;
   endtask

   task automatic send_job(input logic [31:0] d);
      int w = 0;
      while (!hif.job_ready && w < 300) begin
         @(posedge clk); #1; w++;
      end
      if (!hif.job_ready) chk("job_ready_wait", 32'(hif.job_ready), 32'd1);
      rd0 = rd_hits;
      pulse0 = run_pulses;
      hif.job_valid = 1'b1;
      hif.job_data = d;
      @(posedge clk); #1;
      acc_cyc = cyc;
      hif.job_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic wait_run(input int k);
      int w = 0;
      while (run_k != k && w < 100) begin
         @(posedge clk); #1; w++;
      end
      chk("run_cycle_wait", 32'(run_k), 32'(k));
   endtask

   task automatic collect(input vec_t v);
      exp_t e;
      int w = 0;
      while (!hif.res_valid && w < 300) begin
         @(posedge clk); #1; w++;
      end
      chk("res_valid_wait", 32'(hif.res_valid), 32'd1);
      if (v.e_lat > 0) chk("latency", 32'(cyc - acc_cyc + 1), 32'(v.e_lat));
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < v.hold; i++) begin
         chk("hold_valid", 32'(hif.res_valid), 32'd1);
         chk("hold_ready", 32'(hif.job_ready), 32'd0);
         chk("hold_cos", hif.res_cos, e.cosv);
         chk("hold_sin", hif.res_sin, e.sinv);
         chk("hold_cyc", 32'(hif.res_cycles), 32'(e.cyc));
         @(posedge clk); #1;
      end
      chk("res_cos", hif.res_cos, e.cosv);
      chk("res_sin", hif.res_sin, e.sinv);
      chk("res_err", 32'(hif.res_err), 32'(e.err));
      chk("res_cycles", 32'(hif.res_cycles), 32'(e.cyc));
      chk("op_in_ram", ram[OP_A], e.op);
      chk("run_pulses", 32'(run_pulses - pulse0), 32'd1);
      if (e.err) chk("no_readback", 32'(rd_hits - rd0), 32'd0);
      hif.res_ready = 1'b1;
      @(posedge clk); #1;
      hif.res_ready = 1'b0;
      chk("job_ready_after", 32'(hif.job_ready), 32'd1);
      chk("res_valid_after", 32'(hif.res_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      hif.job_valid = 1'b0;
      hif.job_data = 32'h0;
      hif.res_ready = 1'b0;

      tbl[0] = '{32'h0000_2000, 32'h0000_B505, 32'h0000_B505, 10, 1, 0, 0,
                 32'h0000_B505, 32'h0000_B505, 0, 10, 16};
      tbl[1] = '{32'h0000_1234, 32'h1111_0000, 32'h0000_2222, 3, 1, 0, 2,
                 32'h1111_0000, 32'h0000_2222, 0, 3, 9};
      tbl[2] = '{32'h0000_ABCD, 32'h0, 32'h0, 0, 0, 0, 1,
                 32'h0, 32'h0, 1, TMO, TMO + 3};
      tbl[3] = '{32'h0000_0007, 32'h0000_DEAD, 32'h0000_BEEF, 2, 1, 0, 0,
                 32'h0000_DEAD, 32'h0000_BEEF, 0, 2, 8};
      tbl[4] = '{32'h0000_0055, 32'h0000_0101, 32'h0000_0202, 5, 1, 1, 0,
                 32'h0000_0101, 32'h0000_0202, 0, 5, 11};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_job_ready", 32'(hif.job_ready), 32'd1);
      chk("rst_res_valid", 32'(hif.res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_cycles", 32'(hif.res_cycles), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         setup_model(tbl[i]);
         sb.push_back(mk(tbl[i]));
         send_job(tbl[i].op);
         collect(tbl[i]);
      end

      // Backpressure with a second job waiting.
      v = tbl[1];
      v.hold = 20;
      setup_model(v);
      sb.push_back(mk(v));
      send_job(v.op);
      while (!hif.res_valid && cyc - acc_cyc < 300) begin
         @(posedge clk); #1;
      end
      hif.job_valid = 1'b1;
      hif.job_data = tbl[3].op;
      sb.push_back(mk(tbl[3]));
      collect(v);
      setup_model(tbl[3]);
      pulse0 = run_pulses;
      rd0 = rd_hits;
      @(posedge clk); #1;
      acc_cyc = cyc;
      hif.job_valid = 1'b0;
      chk("second_accept", 32'(busy), 32'd1);
      collect(tbl[3]);

      // Port ownership: processor writes only land during RUN.
      v = tbl[0];
      v.e_lat = 0;
      setup_model(v);
      f_en = 1'b1; #1;
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      f_en = 1'b0;
      sb.push_back(mk(v));
      send_job(v.op);
      wait_run(3);
      f_en = 1'b1; #1;
      chk("run_mem_we", 32'(mem_we), 32'd1);
      chk("run_mem_addr", 32'(mem_addr), 32'h10);
      chk("run_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
      f_en = 1'b0;
      while (!hif.res_valid && cyc - acc_cyc < 300) begin
         @(posedge clk); #1;
      end
      f_en = 1'b1; #1;
      chk("present_mem_we", 32'(mem_we), 32'd0);
      f_en = 1'b0;
      collect(v);

      // Reset in the middle of RUN aborts the job.
      setup_model(tbl[0]);
      send_job(32'h0000_0999);
      wait_run(3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cpu_run", 32'(cpu_run), 32'd0);
      chk("abort_res_valid", 32'(hif.res_valid), 32'd0);
      chk("abort_job_ready", 32'(hif.job_ready), 32'd1);
      setup_model(tbl[1]);
      sb.push_back(mk(tbl[1]));
      send_job(tbl[1].op);
      collect(tbl[1]);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cordic_job_sequencer.md
Name: cordic_job_sequencer

Overview:
- Host-side controller for the CORDIC processor and its shared 256x32 data RAM.
- Accepts one job (operand word) over a valid/ready handshake and writes it into RAM.
- Pulses the processor's run, hands the RAM port to the processor until Done, then reads back the cos/sin result words and presents them on a valid/ready result port.
- Sits between the host interface and the processor/RAM pair; owns the single RAM write/address port and muxes it.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 32, RAM data width.
- OP_ADDR, 8'hF0, RAM address receiving the job operand.
- COS_ADDR, 8'hF1, RAM address of the cos result.
- SIN_ADDR, 8'hF2, RAM address of the sin result.
- TIMEOUT, 4096, maximum RUN cycles before abort (>=2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- job_valid  in  1  host offers a job.
- job_ready  out  1  sequencer can accept a job.
- job_data  in  DATA_W  operand word.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes result.
- res_cos  out  DATA_W  word read from COS_ADDR.
- res_sin  out  DATA_W  word read from SIN_ADDR.
- res_err  out  1  1 = job aborted by timeout.
- res_cycles  out  16  RUN cycles spent, saturating at 16'hFFFF.
- busy  out  1  state != IDLE.
- cpu_run  out  1  one-cycle start pulse to the processor.
- cpu_done  in  1  processor Done.
- cpu_we  in  1  processor write enable (W).
- cpu_addr  in  ADDR_W  processor address.
- cpu_wdata  in  DATA_W  processor write data.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_addr is presented (registered read).

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0 except job_ready = 1.
  - Result registers and counters cleared.
  - Reset asserted in any state (including mid-RUN) aborts the job with no result and deasserts cpu_run immediately.
- IDLE:
  - job_ready = 1.
  - Accepts on job_valid && job_ready; latches job_data.
  - Next state WRITE_OP.
- WRITE_OP (1 cycle):
  - mem_we = 1, mem_addr = OP_ADDR, mem_wdata = latched operand.
  - Next state START.
- START (1 cycle):
  - cpu_run = 1; run counter cleared.
  - Next state RUN.
- RUN:
  - RAM port is muxed to the processor: mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
  - Run counter increments each cycle.
  - cpu_done is ignored in the first RUN cycle (stale Done from a previous job); it is sampled from the second cycle on.
  - cpu_done = 1 -> RD_COS.
  - Counter reaches TIMEOUT with no Done -> PRESENT with res_err = 1, res_cos = res_sin = 0.
- Port ownership outside RUN:
  - cpu_we is ignored; the processor can never write RAM.
  - mem_we is driven only by the sequencer.
- Readback:
  - RD_COS: mem_addr = COS_ADDR.
  - RD_SIN: mem_addr = SIN_ADDR; captures mem_rdata into res_cos.
  - CAP_SIN: captures mem_rdata into res_sin.
  - Next state PRESENT; res_err = 0.
- PRESENT:
  - res_valid = 1; res_cos, res_sin, res_err and res_cycles are held stable while res_valid && !res_ready.
  - On handshake -> IDLE; job_ready = 1 on the next cycle.
  - res_ready asserted with res_valid low has no effect.
- Job latency:
  - Accept edge, then WRITE_OP, START, RUN (N cycles), RD_COS, RD_SIN, CAP_SIN, PRESENT.
  - res_valid rises 6+N cycles after the accept edge, where N is the RUN cycle count.
- job_valid while busy: not accepted; the host holds it until job_ready.
- res_cycles: equals the number of RUN cycles, including the Done cycle.
- cpu_run: never asserted outside START.

Decomposition:
- Package cordic_seq_pkg holds:
  - seq_state_t enum: IDLE, WRITE_OP, START, RUN, RD_COS, RD_SIN, CAP_SIN, PRESENT.
  - Default address constants OP_ADDR, COS_ADDR, SIN_ADDR.
  - The width constant 16 for res_cycles.
- Single module; the RAM port mux stays inline. No sub-module is warranted.

Test Plan:
- Processor model writes COS_ADDR = 32'h0000_B505 and SIN_ADDR = 32'h0000_B505 during RUN, then raises Done on RUN cycle 10. Job 32'h0000_2000 -> OP_ADDR written with 32'h0000_2000; one cpu_run pulse; res_valid at accept+16 with res_cos = res_sin = 32'h0000_B505, res_err = 0, res_cycles = 10.
- Backpressure: res_ready held low for 20 cycles -> outputs stable, job_ready = 0; a second job_valid is not accepted until the cycle after the res handshake.
- TIMEOUT = 64, Done never raised -> res_valid with res_err = 1, res_cos = res_sin = 0, res_cycles = 64; no RAM reads issued.
- Stale Done: cpu_done held 1 entering RUN for one cycle, then 0, then 1 at RUN cycle 5 -> readback starts after cycle 5, not cycle 1.
- Processor asserts cpu_we with addr 8'h10 during IDLE and PRESENT -> mem_we stays 0; the same write during RUN appears on mem_we/mem_addr.
- rst asserted at RUN cycle 3 -> next cycle state IDLE, cpu_run = 0, res_valid = 0, job_ready = 1; a new job then completes normally.
